// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the pipeline.
// Opcodes, load/store funct3 codes and MEM stage state.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

endpackage

// File: rtl/rv32_lsu_format.sv
// Byte-lane formatting for loads and stores.
// Pure combinational: be, wdata, misalign, load data.
module rv32_lsu_format
  import rv32_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] load_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  // Store lanes and alignment by access size
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = rs2_i;
    misalign_o = 1'b0;
    case (f3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{rs2_i[15:0]}};
        misalign_o = off_i[0];
      end
      2'b10: misalign_o = |off_i;
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    load_o = sh;
    case (f3_i)
      F3_B:    load_o = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_o = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_o = {24'b0, sh[7:0]};
      F3_HU:   load_o = {16'b0, sh[15:0]};
      default: load_o = sh;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32I MEM stage: data memory access and WB select.
// Holds EX while a dmem request is outstanding.
module rv32_mem_stage
  import rv32_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_in,
  output logic        ex_ready_out,
  input  logic [31:0] ex_iw_in,
  input  logic [31:0] ex_pc_in,
  input  logic [31:0] ex_alu_in,
  input  logic [31:0] ex_rs2_data_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wb_valid_out,
  output logic        wb_we_out,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_data_out,
  output logic [31:0] wb_pc_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  mem_state_t       state_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             ld_q;
  logic [31:0]      pc_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic             wb_valid_q;
  logic             wb_we_q;
  logic             mis_q;
  logic             berr_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_data_q;
  logic [31:0]      wb_pc_q;

  logic             in_wait;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [1:0]       off;
  logic             is_ld;
  logic             is_st;
  logic             is_jmp;
  logic             wb_cls;
  logic             f3_ok;
  logic             go;
  logic             rd_nz;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic             fmt_mis;
  logic [31:0]      fmt_load;
  logic [CNT_W:0]   cnt_nx;
  logic             tmo;
  logic             unused_ok;

  assign in_wait = (state_q == WAIT);
  assign opc     = ex_iw_in[6:0];
  assign f3      = in_wait ? f3_q : ex_iw_in[14:12];
  assign off     = in_wait ? addr_q[1:0] : ex_alu_in[1:0];
  assign rd_nz   = |ex_iw_in[11:7];

  assign unused_ok = ^ex_iw_in[31:15];

  rv32_lsu_format u_fmt (
    .f3_i       (f3),
    .off_i      (off),
    .rs2_i      (ex_rs2_data_in),
    .rdata_i    (dmem_rdata_in),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .misalign_o (fmt_mis),
    .load_o     (fmt_load)
  );

  // Classify the instruction offered by EX
  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_jmp = 1'b0;
    wb_cls = 1'b0;
    unique case (1'b1)
      (opc == OP_LOAD): begin
        is_ld  = 1'b1;
        wb_cls = 1'b1;
      end
      (opc == OP_STORE): is_st = 1'b1;
      (opc == OP_JAL), (opc == OP_JALR): begin
        is_jmp = 1'b1;
        wb_cls = 1'b1;
      end
      (opc == OP_R), (opc == OP_IMM),
      (opc == OP_LUI), (opc == OP_AUIPC):
        wb_cls = 1'b1;
      default: ;
    endcase
  end

  // Legal funct3 for the memory class
  always_comb begin
    f3_ok = 1'b0;
    if (is_ld) begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) ||
              (f3 == F3_W) || (f3 == F3_BU) ||
              (f3 == F3_HU);
    end else if (is_st) begin
      f3_ok = (f3 == F3_B) || (f3 == F3_H) ||
              (f3 == F3_W);
    end
  end

  assign go = (is_ld || is_st) && f3_ok && !fmt_mis;

  // Ack-wait counter: abort once it would reach the limit
  always_comb begin
    cnt_nx = {1'b0, cnt_q} + (CNT_W+1)'(1);
    tmo    = (ACK_TIMEOUT != 0) &&
             (cnt_nx >= (CNT_W+1)'(ACK_TIMEOUT));
  end

  // Stage state, access latches and WB result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      rd_q       <= '0;
      ld_q       <= 1'b0;
      pc_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_pc_q    <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid_in) begin
            if (go) begin
              state_q <= WAIT;
              f3_q    <= ex_iw_in[14:12];
              rd_q    <= ex_iw_in[11:7];
              ld_q    <= is_ld;
              pc_q    <= ex_pc_in;
              addr_q  <= ex_alu_in;
              wdata_q <= fmt_wdata;
              be_q    <= fmt_be;
              we_q    <= is_st;
              cnt_q   <= '0;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= wb_cls && !is_ld && rd_nz;
              wb_rd_q    <= ex_iw_in[11:7];
              wb_pc_q    <= ex_pc_in;
              wb_data_q  <= is_jmp ? ex_pc_in + 32'd4
                                   : ex_alu_in;
              mis_q      <= (is_ld || is_st) && f3_ok;
            end
          end
        end
        WAIT: begin
          if (dmem_ack_in) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= ld_q && (|rd_q);
            wb_rd_q    <= rd_q;
            wb_pc_q    <= pc_q;
            wb_data_q  <= ld_q ? fmt_load : addr_q;
          end else if (tmo) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            berr_q     <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_pc_q    <= pc_q;
            wb_data_q  <= addr_q;
          end else if (!(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_out   = (state_q == IDLE);
  assign dmem_req_out   = in_wait;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[31:2], 2'b00};
  assign dmem_be_out    = be_q;
  assign dmem_wdata_out = wdata_q;

  assign wb_valid_out = wb_valid_q;
  assign wb_we_out    = wb_we_q;
  assign wb_rd_out    = wb_rd_q;
  assign wb_data_out  = wb_data_q;
  assign wb_pc_out    = wb_pc_q;
  assign misalign_out = mis_q;
  assign bus_err_out  = berr_q;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Bench for rv32_mem_stage: directed steps then random
// instructions against a byte-level reference model.
module tb_rv32_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_in;
  logic        ex_ready_out;
  logic [31:0] ex_iw_in;
  logic [31:0] ex_pc_in;
  logic [31:0] ex_alu_in;
  logic [31:0] ex_rs2_data_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [3:0]  dmem_be_out;
  logic [31:0] dmem_wdata_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic        wb_valid_out;
  logic        wb_we_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic [31:0] wb_pc_out;
  logic        misalign_out;
  logic        bus_err_out;

  int errors = 0;
  int checks = 0;

  rv32_mem_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid_in    (ex_valid_in),
    .ex_ready_out   (ex_ready_out),
    .ex_iw_in       (ex_iw_in),
    .ex_pc_in       (ex_pc_in),
    .ex_alu_in      (ex_alu_in),
    .ex_rs2_data_in (ex_rs2_data_in),
    .dmem_req_out   (dmem_req_out),
    .dmem_we_out    (dmem_we_out),
    .dmem_addr_out  (dmem_addr_out),
    .dmem_be_out    (dmem_be_out),
    .dmem_wdata_out (dmem_wdata_out),
    .dmem_ack_in    (dmem_ack_in),
    .dmem_rdata_in  (dmem_rdata_in),
    .wb_valid_out   (wb_valid_out),
    .wb_we_out      (wb_we_out),
    .wb_rd_out      (wb_rd_out),
    .wb_data_out    (wb_data_out),
    .wb_pc_out      (wb_pc_out),
    .misalign_out   (misalign_out),
    .bus_err_out    (bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        go;
    bit        st;
    bit        mis;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit        wb_we;
    bit [31:0] data;
  } exp_t;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd);
    mk = {17'h0, f3, rd, op};
  endfunction

  // Reference: access size in bytes, lane arithmetic
  function automatic exp_t model(input logic [31:0] iw,
                                 input logic [31:0] pc,
                                 input logic [31:0] alu,
                                 input logic [31:0] rs2,
                                 input logic [31:0] rdata);
    exp_t e;
    logic [6:0] op = iw[6:0];
    int f3 = int'(iw[14:12]);
    int off = int'(alu[1:0]);
    int sz = 1 << (f3 % 4);
    bit ld = (op == 7'b0000011);
    bit st = (op == 7'b0100011);
    bit jmp = (op == 7'b1101111) || (op == 7'b1100111);
    bit ok;
    bit wcls;
    logic [31:0] w, m, lv;
    e = '{default: 0};
    ok = ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 <= 2);
    e.go = (ld || st) && ok && ((off % sz) == 0);
    e.mis = (ld || st) && ok && ((off % sz) != 0);
    e.st = st;
    e.addr = alu & 32'hFFFF_FFFC;
    lv = alu;
    if (e.go) begin
      e.be = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++)
        e.wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
      w = rdata >> (8 * off);
      m = (sz == 4) ? 32'hFFFF_FFFF
                    : (32'd1 << (8 * sz)) - 32'd1;
      lv = w & m;
      if (f3 < 4 && sz < 4 && w[8*sz-1]) lv = lv | ~m;
    end
    wcls = op inside {7'b0110011, 7'b0010011, 7'b0000011,
                      7'b1101111, 7'b1100111, 7'b0110111,
                      7'b0010111};
    e.wb_we = wcls && (iw[11:7] != 0) && (!ld || e.go);
    if (ld && e.go) e.data = lv;
    else if (jmp) e.data = pc + 32'd4;
    else e.data = alu;
    return e;
  endfunction

  // Issue one instruction at a negedge; dly<0 = never ack
  task automatic run(input logic [31:0] iw,
                     input logic [31:0] pc,
                     input logic [31:0] alu,
                     input logic [31:0] rs2,
                     input logic [31:0] rdata,
                     input int dly);
    exp_t e;
    int n;
    bit tmo;
    e = model(iw, pc, alu, rs2, rdata);
    tmo = e.go && (dly < 0);
    chk("ready_idle", ex_ready_out, 1);
    ex_iw_in = iw;
    ex_pc_in = pc;
    ex_alu_in = alu;
    ex_rs2_data_in = rs2;
    ex_valid_in = 1'b1;
    @(negedge clk);
    if (e.go && !tmo) begin
      repeat (dly) begin
        chk("req_hold", dmem_req_out, 1);
        chk("ready_wait", ex_ready_out, 0);
        @(negedge clk);
      end
      chk("req", dmem_req_out, 1);
      chk("ready_wait", ex_ready_out, 0);
      chk("addr", dmem_addr_out, e.addr);
      chk("be", dmem_be_out, e.be);
      chk("we", dmem_we_out, e.st);
      if (e.st) chk("wdata", dmem_wdata_out, e.wdata);
      ex_valid_in = 1'b0;
      dmem_ack_in = 1'b1;
      dmem_rdata_in = rdata;
      @(negedge clk);
      dmem_ack_in = 1'b0;
    end else if (tmo) begin
      ex_valid_in = 1'b0;
      n = 0;
      while (dmem_req_out === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_req_cycles", n, 4);
    end else begin
      ex_valid_in = 1'b0;
      chk("no_req", dmem_req_out, 0);
    end
    chk("wb_valid", wb_valid_out, 1);
    chk("wb_rd", wb_rd_out, iw[11:7]);
    chk("wb_pc", wb_pc_out, pc);
    chk("wb_we", wb_we_out, tmo ? 1'b0 : e.wb_we);
    chk("misalign", misalign_out, e.mis);
    chk("bus_err", bus_err_out, tmo);
    if (!tmo) chk("wb_data", wb_data_out, e.data);
  endtask

  logic [6:0] ops [10];
  logic [2:0] f3r;
  logic [6:0] opr;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b1100011, 7'b0000000};
    rst_n = 1'b0;
    ex_valid_in = 1'b0;
    ex_iw_in = '0;
    ex_pc_in = '0;
    ex_alu_in = '0;
    ex_rs2_data_in = '0;
    dmem_ack_in = 1'b0;
    dmem_rdata_in = '0;
    @(negedge clk);
    chk("rst_ready", ex_ready_out, 1);
    chk("rst_req", dmem_req_out, 0);
    chk("rst_we", dmem_we_out, 0);
    chk("rst_addr", dmem_addr_out, 0);
    chk("rst_be", dmem_be_out, 0);
    chk("rst_wdata", dmem_wdata_out, 0);
    chk("rst_wb_valid", wb_valid_out, 0);
    chk("rst_wb_data", wb_data_out, 0);
    chk("rst_err", {misalign_out, bus_err_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x3 = 5, then result must be a single pulse
    run(mk(7'b0010011, 3'b000, 5'd3), 32'h100,
        32'd5, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("wb_one_pulse", wb_valid_out, 0);

    // Ack while idle does nothing
    dmem_ack_in = 1'b1;
    @(negedge clk);
    dmem_ack_in = 1'b0;
    chk("idle_ack_wb", wb_valid_out, 0);
    chk("idle_ack_req", dmem_req_out, 0);

    // SB to byte 3, ack after two wait cycles
    run(mk(7'b0100011, 3'b000, 5'd0), 32'h104,
        32'h1003, 32'hAABBCCDD, 32'h0, 2);
    // LB / LBU / LHU with same-cycle ack
    run(mk(7'b0000011, 3'b000, 5'd4), 32'h108,
        32'h2001, 32'h0, 32'h1234_80FF, 0);
    chk("lb_value", wb_data_out, 32'hFFFF_FF80);
    run(mk(7'b0000011, 3'b100, 5'd5), 32'h10C,
        32'h2001, 32'h0, 32'h1234_80FF, 0);
    chk("lbu_value", wb_data_out, 32'h0000_0080);
    run(mk(7'b0000011, 3'b101, 5'd6), 32'h110,
        32'h2002, 32'h0, 32'h1234_80FF, 0);
    chk("lhu_value", wb_data_out, 32'h0000_1234);
    // Misaligned LW
    run(mk(7'b0000011, 3'b010, 5'd7), 32'h114,
        32'h3002, 32'h0, 32'h0, 0);
    chk("lw_mis_flag", misalign_out, 1);
    // LW never acked: timeout after 4 request cycles
    run(mk(7'b0000011, 3'b010, 5'd8), 32'h118,
        32'h4000, 32'h0, 32'h0, -1);
    @(negedge clk);
    chk("tmo_req_low", dmem_req_out, 0);
    // JAL at top of memory wraps
    run(mk(7'b1101111, 3'b000, 5'd1), 32'hFFFF_FFFC,
        32'h0, 32'h0, 32'h0, 0);
    chk("jal_wrap", wb_data_out, 32'h0);

    // Async reset in the middle of a wait
    ex_iw_in = mk(7'b0000011, 3'b010, 5'd9);
    ex_alu_in = 32'h5000;
    ex_valid_in = 1'b1;
    @(negedge clk);
    ex_valid_in = 1'b0;
    chk("pre_rst_req", dmem_req_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", dmem_req_out, 0);
    chk("rst_ready_up", ex_ready_out, 1);
    dmem_ack_in = 1'b1;
    dmem_rdata_in = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_wb", wb_valid_out, 0);
    chk("late_ack_req", dmem_req_out, 0);
    dmem_ack_in = 1'b0;
    @(negedge clk);

    // Random instruction mix
    for (int k = 0; k < 300; k++) begin
      opr = ops[$urandom_range(0, 9)];
      f3r = 3'($urandom_range(0, 7));
      run(mk(opr, f3r, 5'($urandom_range(0, 31))),
          $urandom, $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
